spi_slave_rx: RTL and testbench

Receive-side SPI slave that deserializes the three-wire `sync`/`mosi`/`sclk` stream produced by the tone/sample SPI master back into parallel words. It oversamples the serial lines in the system clock domain, frames words on `sync`, and buffers completed words in a small FIFO with a valid/ready output. It is the capture front-end for loopback verification and for boards that consume the audio SPI stream.

---
 rtl/spi_slave_rx.sv | 159 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
// spi_slave_rx: oversampling SPI receiver. Synchronizes sclk/sync/mosi into
// the clk domain, frames MSB-first words on sync and queues completed words
// in a small FIFO presented with a valid/ready handshake.
module spi_slave_rx #(
  parameter int WORD_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sync,
  input  logic                 mosi,
  input  logic                 rx_ready,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int CW = $clog2(WORD_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Synchronizers; the sclk chain has a third stage for edge detection
  logic [2:0]           r_sclk_sync;
  logic [1:0]           r_sync_sync;
  logic [1:0]           r_mosi_sync;

  // Framing state
  state_t               r_state;
  logic [CW-1:0]        r_count;
  logic [WORD_BITS-2:0] r_shreg;
  logic                 r_busy;
  logic                 r_frame_err;

  // FIFO storage and pointers (one extra wrap bit each)
  logic [WORD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;
  logic                 r_overflow;

  logic                 w_rise;
  logic                 w_sync;
  logic                 w_mosi;
  logic [WORD_BITS-1:0] w_word;
  logic                 w_push;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;

  assign w_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sync = r_sync_sync[1];
  assign w_mosi = r_mosi_sync[1];
  assign w_word = {r_shreg, w_mosi};

  // The only shift that completes a word is the one arriving at count WORD_BITS-1
  assign w_push = w_rise & ~w_sync & (r_state == ST_SHIFT) &
                  (r_count == CW'(WORD_BITS - 1));

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & rx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives
  assign w_wr    = w_push & (~w_full | w_pop);

  // Two-flop synchronizers plus the sclk edge-detect stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_sync_sync <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk};
      r_sync_sync <= {r_sync_sync[0], sync};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
    end
  end

  // Framing FSM: bit counting, shifting and the frame error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_shreg     <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_rise) begin
        case (r_state)
          ST_IDLE: begin
            if (w_sync) begin
              r_state <= ST_SHIFT;
              r_count <= '0;
              r_busy  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (w_sync) begin
              if (r_count != '0) begin
                r_frame_err <= 1'b1;
              end
              r_count <= '0;
            end else begin
              r_shreg <= w_word[WORD_BITS-2:0];
              if (r_count == CW'(WORD_BITS - 1)) begin
                r_count <= '0;
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_count <= r_count + CW'(1);
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Word FIFO: push from the framer, pop on valid & ready, flag dropped words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push & w_full & ~w_pop;
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= w_word;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  assign rx_data   = r_mem[r_rptr[AW-1:0]];
  assign rx_valid  = ~w_empty;
  assign rx_busy   = r_busy;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
// Testbench for spi_slave_rx: scoreboard of expected words, popped and
// compared whenever the DUT hands a word over on valid & ready.
module tb_spi_slave_rx;

  localparam int WB = 16;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          sclk_pin = 1'b0;
  logic          sync_pin = 1'b0;
  logic          mosi_pin = 1'b0;
  logic          rx_ready = 1'b0;
  logic [WB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_err;
  logic          overflow;

  int errors   = 0;
  int checks   = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int pop_cnt  = 0;
  logic [WB-1:0] exp_q[$];
  logic [WB-1:0] mon_exp;

  always #5 clk = ~clk;

  spi_slave_rx #(.WORD_BITS(WB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk_pin),
    .sync      (sync_pin),
    .mosi      (mosi_pin),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // Monitor: count pulse samples and check every handed-over word
  always @(negedge clk) begin
    #1;
    if (frame_err === 1'b1) ferr_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      checks++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no word", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got %h, required %h", rx_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // One sclk period of 4 clk: data changes 1 clk before the rise, held 3 after
  task automatic spi_bit(input logic s, input logic m);
    sync_pin = s;
    mosi_pin = m;
    @(negedge clk);
    sclk_pin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sclk_pin = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [WB-1:0] w, input bit expect_word,
                            input bit ready_pulse);
    spi_bit(1'b1, 1'b1);
    for (int i = WB - 1; i >= 1; i--) spi_bit(1'b0, w[i]);
    if (expect_word) exp_q.push_back(w);
    sync_pin = 1'b0;
    mosi_pin = w[0];
    @(negedge clk);
    sclk_pin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (ready_pulse) rx_ready = 1'b1;
    sclk_pin = 1'b0;
    @(negedge clk);
    if (ready_pulse) rx_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: rx_valid=%b, required 0", rx_valid);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (rx_data !== '0 || rx_valid !== 1'b0 || rx_busy !== 1'b0 ||
        frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s: data=%h valid=%b busy=%b ferr=%b ovf=%b, required all 0",
               tag, rx_data, rx_valid, rx_busy, frame_err, overflow);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int f0, o0;
    logic [WB-1:0] w;
    w = 16'hA5C3;
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    rx_ready = 1'b1;
    spi_bit(1'b1, 1'b0);
    for (int i = WB - 1; i >= 1; i--) spi_bit(1'b0, w[i]);
    exp_q.push_back(w);
    sync_pin = 1'b0;
    mosi_pin = w[0];
    @(negedge clk);
    sclk_pin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: rx_valid=%b after 2 edges, required 0", rx_valid);
    end
    sclk_pin = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== w) begin
      errors++;
      $display("FAIL single_latency: valid=%b data=%h, required 1 %h", rx_valid, rx_data, w);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: rx_valid=%b, required 0", rx_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ferr_cnt != f0 || ovf_cnt != o0) begin
      errors++;
      $display("FAIL single_flags: ferr=%0d ovf=%0d pulses, required 0 0",
               ferr_cnt - f0, ovf_cnt - o0);
    end
  endtask

  task automatic test_overflow();
    int f0, o0;
    f0 = ferr_cnt;
    o0 = ovf_cnt;
    rx_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(WB'(k), k <= 4, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ovf_cnt - o0 != 1) begin
      errors++;
      $display("FAIL overflow_pulse: %0d cycles high, required 1", ovf_cnt - o0);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL overflow_ferr: %0d pulses, required 0", ferr_cnt - f0);
    end
    drain();
  endtask

  task automatic test_short_frame();
    int f0;
    f0 = ferr_cnt;
    rx_ready = 1'b1;
    spi_bit(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) spi_bit(1'b0, 1'b1);
    send_frame(16'h1234, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL short_ferr: %0d cycles high, required 1", ferr_cnt - f0);
    end
    drain();
  endtask

  task automatic test_stray_and_full();
    int p0, o0;
    rx_ready = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 20; i++) spi_bit(1'b0, 1'($urandom));
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_busy !== 1'b0 || pop_cnt != p0) begin
      errors++;
      $display("FAIL stray_edges: valid=%b busy=%b pops=%0d, required 0 0 0",
               rx_valid, rx_busy, pop_cnt - p0);
    end
    rx_ready = 1'b0;
    o0 = ovf_cnt;
    send_frame(16'h1111, 1'b1, 1'b0);
    send_frame(16'h2222, 1'b1, 1'b0);
    send_frame(16'h3333, 1'b1, 1'b0);
    send_frame(16'h4444, 1'b1, 1'b0);
    send_frame(16'h5555, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (ovf_cnt != o0) begin
      errors++;
      $display("FAIL full_pushpop_ovf: %0d cycles high, required 0", ovf_cnt - o0);
    end
    p0 = pop_cnt;
    drain();
    checks++;
    if (pop_cnt - p0 != 4) begin
      errors++;
      $display("FAIL full_occupancy: drained %0d words, required 4", pop_cnt - p0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hA5;
    rx_ready = 1'b1;
    spi_bit(1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) spi_bit(1'b0, b[i]);
    #1;
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: rx_busy=%b, required 1", rx_busy);
    end
    rst = 1'b1;
    #1;
    check_outputs_zero("midframe_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(1'b0, b[i]);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_tail: valid=%b busy=%b, required 0 0", rx_valid, rx_busy);
    end
    send_frame(16'hBEEF, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = ferr_cnt;
    rx_ready = 1'b1;
    send_frame(16'hFFFF, 1'b1, 1'b0);
    send_frame(16'h0000, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL b2b_ferr: %0d pulses, required 0", ferr_cnt - f0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_short_frame();
    test_stray_and_full();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
